// File: rtl/datamem_pkg.sv
// Shared types and constants for the MEM-stage data-memory sequencer.
package datamem_pkg;

  localparam int          DATA_WIDTH_DEF = 32;
  localparam logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/datamem_sequencer_if.sv
// Data-memory req/gnt/rvalid bus. The sequencer is the master; memory is the slave.
interface datamem_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/datamem_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones, never wraps.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  // Clear has priority over count; counting stops at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   q <= '0;
    else if (clr)              q <= '0;
    else if (en && (q != '1))  q <= q + 1'b1;
  end

endmodule

// File: rtl/datamem_sequencer.sv
// MEM-stage data-memory sequencer: issues req/gnt accesses, stalls the upstream
// pipeline while an access is outstanding, and holds load data for MEM/WB.
// Optional feature macro: MEM_TIMEOUT_EN (watchdog that aborts a stuck access,
// returns TIMEOUT_RDATA for loads and sets sticky MemErr).
module datamem_sequencer
  import datamem_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  datamem_sequencer_if.master   mem,
  output logic                  StallM,
  output logic [DATA_WIDTH-1:0] RD,
  output logic [CNT_WIDTH-1:0]  StallCount,
  output logic                  MemErr
);

  state_t state, nxt;
  logic   access;
  logic   capture;
  logic   timeout;

  assign access        = MemReadM | MemWriteM;
  // EX/MEM is frozen by StallM, so these are stable for the whole access.
  assign mem.mem_addr  = ALUResultM;
  assign mem.mem_wdata = WriteDataM;

`ifdef MEM_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] to_cnt;

  // Counts every stalled cycle of the current access; zero whenever not stalled,
  // so each new access starts from 0.
  sat_counter #(.W(TW)) u_to_cnt (
    .clk (clk),
    .rst (rst),
    .en  (StallM),
    .clr (~StallM),
    .q   (to_cnt)
  );
`endif

  // State register; async reset drops mem_req/StallM immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state and combinational bus/stall outputs.
  always_comb begin
    nxt         = state;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    StallM      = 1'b0;
    capture     = 1'b0;
    timeout     = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          mem.mem_req = 1'b1;
          mem.mem_we  = MemWriteM;
          StallM      = 1'b1;
          if (mem.mem_gnt) nxt = MemWriteM ? DONE : WAIT;
        end
      end
      WAIT: begin
        StallM = 1'b1;
        if (mem.mem_rvalid) begin
          capture = 1'b1;
          nxt     = DONE;
        end
      end
      // One advance cycle; always back to IDLE so the finished access is never re-issued.
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
`ifdef MEM_TIMEOUT_EN
    if (StallM && (to_cnt == TW'(TIMEOUT_CYCLES - 1)) && (nxt != DONE)) begin
      timeout = 1'b1;
      nxt     = DONE;
    end
`endif
  end

  // Load data register; held across stores and idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       RD <= '0;
    else if (capture)              RD <= mem.mem_rdata;
    else if (timeout && MemReadM)  RD <= DATA_WIDTH'(TIMEOUT_RDATA);
  end

`ifdef MEM_TIMEOUT_EN
  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          MemErr <= 1'b0;
    else if (timeout) MemErr <= 1'b1;
  end
`else
  assign MemErr = 1'b0;
`endif

  sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (StallM),
    .clr (1'b0),
    .q   (StallCount)
  );

endmodule

// File: doc/datamem_sequencer.md
Name: datamem_sequencer

Overview:
- Sequences data-memory accesses for the MEM stage of the 5-stage RV32 pipeline, against a data memory with a variable-latency req/gnt/rvalid interface.
- Freezes the upstream pipeline registers while an access is outstanding.
- Holds captured read data stable and presents it on the RD input of the MEM/WB register for exactly one advance cycle.
- Sits between MEM-stage control (MemReadM/MemWriteM) and data memory; the hazard unit ORs StallM into its stall/enable terms.

Parameters:
- DATA_WIDTH, 32, width of address, write data and read data.
- CNT_WIDTH, 32, width of the saturating stall-cycle counter.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- MemReadM  in  1  MEM-stage instruction is a load.
- MemWriteM  in  1  MEM-stage instruction is a store. Never asserted together with MemReadM.
- ALUResultM  in  DATA_WIDTH  access address.
- WriteDataM  in  DATA_WIDTH  store data.
- mem_req  out  1  access request.
- mem_we  out  1  1 = write, 0 = read. Valid while mem_req=1.
- mem_addr  out  DATA_WIDTH  equals ALUResultM.
- mem_wdata  out  DATA_WIDTH  equals WriteDataM.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_WIDTH  read data.
- StallM  out  1  freeze PC and the IF/ID, ID/EX and EX/MEM registers.
- RD  out  DATA_WIDTH  read data to the MEM/WB register.
- StallCount  out  CNT_WIDTH  saturating count of cycles with StallM=1.
- MemErr  out  1  sticky timeout flag.

Behaviour:
- Reset: clk and rst are the only clock and reset; rst is asynchronous and active-high.
  - State = IDLE.
  - RD = 0, StallCount = 0, MemErr = 0.
  - mem_req = 0 and StallM = 0 (combinational from state).
- FSM states: IDLE, WAIT, DONE.
- Outputs are combinational from state and inputs; RD, StallCount and MemErr are registered.
- mem_addr and mem_wdata always follow the inputs. They stay stable during an access because StallM freezes EX/MEM.
- IDLE, no access (MemReadM|MemWriteM = 0):
  - StallM = 0, mem_req = 0, stay in IDLE.
- IDLE, access present:
  - mem_req = 1, mem_we = MemWriteM, StallM = 1.
  - If mem_gnt=1: store goes to DONE; load goes to WAIT.
  - If mem_gnt=0: stay in IDLE and keep requesting. The request must remain asserted until granted.
- WAIT:
  - mem_req = 0, StallM = 1.
  - On mem_rvalid: RD <= mem_rdata, go to DONE.
  - mem_rvalid is sampled only in WAIT; rvalid in any other state is ignored.
- DONE:
  - StallM = 0, mem_req = 0. The pipeline advances and MEM/WB captures RD.
  - Next state is always IDLE. This guarantees the just-completed instruction is never re-issued.
  - A back-to-back access in the next MEM instruction starts in the following IDLE cycle.
- Latency:
  - Store with immediate gnt: 1 stall cycle.
  - Load with gnt in cycle 0 and rvalid in cycle 1: 2 stall cycles; RD is valid in cycle 2 (DONE).
- RD is held until the next load capture; stores do not modify RD.
- StallCount increments each cycle StallM=1 and saturates at all-ones; it does not wrap.
- Reset mid-access: FSM returns to IDLE immediately and mem_req drops asynchronously. A late rvalid after reset is ignored.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A wait counter clears on entry to an access and counts cycles spent in IDLE-requesting or WAIT.
  - When the count reaches TIMEOUT_CYCLES-1 without completion: go to DONE, RD <= 32'hDEAD_BEEF for loads, MemErr <= 1.
  - MemErr is sticky until rst.
- MEM_TIMEOUT_EN undefined:
  - No counter is built, MemErr is tied to 0, and the FSM waits indefinitely.

Decomposition:
- Package datamem_pkg: state enum (IDLE, WAIT, DONE), DATA_WIDTH default, TIMEOUT_RDATA constant 32'hDEAD_BEEF.
- One natural sub-module: sat_counter, a parameterised saturating counter with enable and clear. It is used for StallCount and for the timeout counter.

Test Plan:
- Load at 0x100, gnt in cycle 0, rvalid in cycle 1 with rdata 0x12345678 -> StallM=1 for 2 cycles; DONE cycle has StallM=0 and RD=0x12345678; StallCount=2.
- Store 0xCAFEF00D to 0x200, gnt delayed 3 cycles -> mem_req held high 4 cycles with mem_we=1 and stable addr/wdata; 4 stall cycles, then DONE; RD unchanged.
- Back-to-back load then store -> one DONE cycle between them, with mem_req=0 in DONE; the second access begins the next cycle; the first is never re-issued.
- Spurious mem_rvalid=1 while in IDLE with no access -> RD unchanged, StallM=0.
- rst asserted during WAIT, then rvalid arrives -> state IDLE, mem_req=0, RD=0, StallCount=0; rvalid ignored.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, load with no gnt -> after 8 stall cycles enters DONE with RD=0xDEADBEEF and MemErr=1; MemErr stays 1 until rst.
